// File: rtl/onehot_index_encoder.sv
// onehot_index_encoder
// Sequential priority encoder. It accepts a 2^N-bit request vector, then
// streams out the binary index of every set bit, one index per cycle, from the
// highest index down to the lowest.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous, active-low reset
//   in_valid   request vector present
//   in_ready   block can accept a vector (only while idle)
//   in_req     request vector, bit i set means index i is requested
//   out_valid  out_idx is valid
//   out_ready  consumer accepts out_idx
//   out_idx    highest-numbered pending index (0 while out_valid is low)
//   out_last   out_idx is the final index of the current vector
//   zero_err   one-cycle pulse after an all-zero vector is accepted
module onehot_index_encoder #(
   parameter int N = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [(1<<N)-1:0] in_req,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [N-1:0]      out_idx,
   output logic              out_last,
   output logic              zero_err
);

   localparam int W = 1 << N;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   state_t         state;
   state_t         state_next;
   logic [W-1:0]   pending;
   logic [W-1:0]   pending_next;
   logic           zero_next;
   logic [N-1:0]   hi_idx;
   logic           one_left;
   logic [W-1:0]   clear_mask;

   // Highest set bit of pending. The ascending loop lets later (higher)
   // set bits overwrite earlier ones, leaving the top index.
   always_comb begin
      hi_idx = '0;
      for (int i = 0; i < W; i++) begin
         if (pending[i]) begin
            hi_idx = i[N-1:0];
         end
      end
   end

   // Exactly one bit left: non-zero and clearing the lowest set bit empties it.
   assign one_left   = (pending != '0) && ((pending & (pending - W'(1))) == '0);
   assign clear_mask = ~(W'(1) << hi_idx);

   // Handshake flags come straight from the state register, so an
   // asynchronous reset forces them to their idle values at once.
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == EMIT);
   assign out_idx   = out_valid ? hi_idx : '0;
   assign out_last  = out_valid && one_left;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. A zero vector is accepted but never enters EMIT; it
   // only raises the error pulse for the following cycle.
   always_comb begin
      state_next   = state;
      pending_next = pending;
      zero_next    = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               if (in_req != '0) begin
                  pending_next = in_req;
                  state_next   = EMIT;
               end else begin
                  zero_next = 1'b1;
               end
            end
         end
         EMIT: begin
            if (out_ready) begin
               pending_next = pending & clear_mask;
               if (one_left) begin
                  state_next = IDLE;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Pending bits and the registered zero-vector pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending  <= '0;
         zero_err <= 1'b0;
      end else begin
         pending  <= pending_next;
         zero_err <= zero_next;
      end
   end

endmodule

// File: tb/tb_onehot_index_encoder.sv
// tb_onehot_index_encoder
// Self-checking bench for onehot_index_encoder. One instance uses N=3, a
// second uses N=1. Expected index sequences come from a simple model: scan
// the request vector from its top bit down and queue each set position.
module tb_onehot_index_encoder;

   logic       clk;
   logic       rst_n;

   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_req;
   logic       out_valid;
   logic       out_ready;
   logic [2:0] out_idx;
   logic       out_last;
   logic       zero_err;

   logic       n_in_valid;
   logic       n_in_ready;
   logic [1:0] n_in_req;
   logic       n_out_valid;
   logic       n_out_ready;
   logic [0:0] n_out_idx;
   logic       n_out_last;
   logic       n_zero_err;

   int checks;
   int errors;

   onehot_index_encoder #(.N(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_req    (in_req),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .zero_err  (zero_err)
   );

   onehot_index_encoder #(.N(1)) dut_narrow (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (n_in_valid),
      .in_ready  (n_in_ready),
      .in_req    (n_in_req),
      .out_valid (n_out_valid),
      .out_ready (n_out_ready),
      .out_idx   (n_out_idx),
      .out_last  (n_out_last),
      .zero_err  (n_zero_err)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Sends one vector to the N=3 instance and follows it through every beat.
   // mode: 0 ready always, 1 ready toggling 1,0,1,..., 2 random ready,
   // 3 ready held low for the first 3 cycles. poke drives a stray vector
   // during emission, which must be ignored.
   task automatic applyStimulus(input logic [7:0] v, input int mode, input bit poke);
      int q[$];
      int cyc;
      bit rdy;
      for (int i = 7; i >= 0; i--) begin
         if (v[i]) q.push_back(i);
      end
      @(negedge clk);
      checkOutput("idle_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_req   = v;
      @(negedge clk);
      in_valid = 1'b0;
      in_req   = '0;
      if (q.size() == 0) begin
         checkOutput("zero_err_high", 32'(zero_err), 32'd1);
         checkOutput("zero_out_valid", 32'(out_valid), 32'd0);
         checkOutput("zero_in_ready", 32'(in_ready), 32'd1);
         @(negedge clk);
         checkOutput("zero_err_low", 32'(zero_err), 32'd0);
         return;
      end
      cyc = 0;
      while (q.size() > 0 && cyc < 200) begin
         case (mode)
            1:       rdy = (cyc % 2 == 0);
            2:       rdy = 1'($urandom_range(0, 1));
            3:       rdy = (cyc >= 3);
            default: rdy = 1'b1;
         endcase
         out_ready = rdy;
         if (poke) begin
            in_valid = 1'b1;
            in_req   = 8'h01;
         end
         checkOutput("beat_valid", 32'(out_valid), 32'd1);
         checkOutput("beat_idx", 32'(out_idx), 32'(q[0]));
         checkOutput("beat_last", 32'(out_last), 32'(q.size() == 1));
         checkOutput("beat_in_ready", 32'(in_ready), 32'd0);
         checkOutput("beat_zero_err", 32'(zero_err), 32'd0);
         @(negedge clk);
         if (rdy) void'(q.pop_front());
         cyc++;
      end
      in_valid  = 1'b0;
      in_req    = '0;
      out_ready = 1'b0;
      checkOutput("beat_timeout", 32'(q.size()), 32'd0);
      checkOutput("done_in_ready", 32'(in_ready), 32'd1);
      checkOutput("done_out_valid", 32'(out_valid), 32'd0);
      checkOutput("done_out_idx", 32'(out_idx), 32'd0);
      checkOutput("done_out_last", 32'(out_last), 32'd0);
   endtask

   // Same flow for the N=1 instance with the consumer always ready.
   task automatic applyStimulusNarrow(input logic [1:0] v);
      int q[$];
      int cyc;
      for (int i = 1; i >= 0; i--) begin
         if (v[i]) q.push_back(i);
      end
      @(negedge clk);
      checkOutput("n_idle_in_ready", 32'(n_in_ready), 32'd1);
      n_in_valid = 1'b1;
      n_in_req   = v;
      @(negedge clk);
      n_in_valid  = 1'b0;
      n_in_req    = '0;
      n_out_ready = 1'b1;
      cyc = 0;
      while (q.size() > 0 && cyc < 20) begin
         checkOutput("n_beat_valid", 32'(n_out_valid), 32'd1);
         checkOutput("n_beat_idx", 32'(n_out_idx), 32'(q[0]));
         checkOutput("n_beat_last", 32'(n_out_last), 32'(q.size() == 1));
         @(negedge clk);
         void'(q.pop_front());
         cyc++;
      end
      n_out_ready = 1'b0;
      checkOutput("n_done_out_valid", 32'(n_out_valid), 32'd0);
      checkOutput("n_done_in_ready", 32'(n_in_ready), 32'd1);
   endtask

   initial begin
      logic [7:0] rv;
      checks      = 0;
      errors      = 0;
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      in_req      = '0;
      out_ready   = 1'b0;
      n_in_valid  = 1'b0;
      n_in_req    = '0;
      n_out_ready = 1'b0;

      // Reset state.
      #12;
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_out_idx", 32'(out_idx), 32'd0);
      checkOutput("rst_out_last", 32'(out_last), 32'd0);
      checkOutput("rst_zero_err", 32'(zero_err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors.
      applyStimulus(8'b1010_0100, 0, 1'b0);
      applyStimulus(8'b1010_0100, 3, 1'b0);
      applyStimulus(8'h00, 0, 1'b0);
      applyStimulus(8'hFF, 1, 1'b1);
      applyStimulus(8'h08, 0, 1'b0);

      // Back-to-back zero vectors give back-to-back pulses.
      @(negedge clk);
      in_valid = 1'b1;
      in_req   = 8'h00;
      @(negedge clk);
      checkOutput("zz_pulse1", 32'(zero_err), 32'd1);
      @(negedge clk);
      checkOutput("zz_pulse2", 32'(zero_err), 32'd1);
      checkOutput("zz_out_valid", 32'(out_valid), 32'd0);
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("zz_fall", 32'(zero_err), 32'd0);

      // Asynchronous reset in the middle of a burst.
      @(negedge clk);
      in_valid = 1'b1;
      in_req   = 8'hC3;
      @(negedge clk);
      in_valid  = 1'b0;
      in_req    = '0;
      out_ready = 1'b1;
      checkOutput("mid_idx7", 32'(out_idx), 32'd7);
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput("mid_idx6", 32'(out_idx), 32'd6);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_out_valid", 32'(out_valid), 32'd0);
      checkOutput("async_in_ready", 32'(in_ready), 32'd1);
      checkOutput("async_out_idx", 32'(out_idx), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(8'h10, 0, 1'b0);

      // Randomized vectors with random consumer back-pressure.
      for (int k = 0; k < 25; k++) begin
         rv = 8'($urandom);
         if (k % 8 == 0) rv = 8'h00;
         applyStimulus(rv, 2, 1'($urandom_range(0, 1)));
      end

      // Narrow build.
      applyStimulusNarrow(2'b11);
      applyStimulusNarrow(2'b01);
      applyStimulusNarrow(2'b10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
